cache_block_ram: RTL and testbench

Synchronous simple-dual-port RAM used for every storage array in an oldland cache way: tag, valid and dirty arrays in plain full-width mode, and the line-data array in byte-enabled 32-bit mode. It has one write port and one registered read port, with write-to-read bypass so the cache FSM sees same-cycle updates. Memory contents are never cleared by reset. Invalidation is done by the cache writing the valid array.

---
 rtl/cache_block_ram.sv | 73 +++++++
 tb/tb_cache_block_ram.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cache_block_ram.sv
// Simple-dual-port cache storage array: one write port, one registered read port,
// write-first bypass, optional per-byte write enables for the line-data array.
module cache_block_ram #(
  parameter int data_bits   = 32,
  parameter int nr_entries  = 128,
  parameter int use_bytesel = 0,
  localparam int ADDR_BITS  = (nr_entries > 1) ? $clog2(nr_entries) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] read_addr,
  output logic [data_bits-1:0] read_data,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] write_addr,
  input  logic [data_bits-1:0] write_data,
  input  logic [3:0]           bytesel
);

  localparam logic [ADDR_BITS:0] LIMIT = (ADDR_BITS + 1)'(nr_entries);
  localparam logic WORD_MODE = (use_bytesel == 0);

  // Contents start at zero so the valid array begins with every way invalid.
  logic [data_bits-1:0] mem_r [nr_entries] = '{default: '0};

  logic                 wr_in_range_s;
  logic                 rd_in_range_s;
  logic                 bypass_s;
  logic [data_bits-1:0] write_mask_s;
  logic [data_bits-1:0] old_word_s;
  logic [data_bits-1:0] new_word_s;

  assign wr_in_range_s = ({1'b0, write_addr} < LIMIT);
  assign rd_in_range_s = ({1'b0, read_addr} < LIMIT);
  assign bypass_s      = wr_en && wr_in_range_s && (write_addr == read_addr);

  // In word mode every bit is enabled regardless of bytesel.
  for (genvar b = 0; b < data_bits; b++) begin : g_mask
    assign write_mask_s[b] = bytesel[(b / 8) % 4] | WORD_MODE;
  end

  // Old word at the write address, needed for the byte merge.
  always_comb begin
    old_word_s = '0;
    if (wr_in_range_s) begin
      old_word_s = mem_r[write_addr];
    end else begin
      old_word_s = '0;
    end
  end

  assign new_word_s = (old_word_s & ~write_mask_s) | (write_data & write_mask_s);

  // Write port; reset deliberately leaves the array untouched.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range_s) begin
      mem_r[write_addr] <= new_word_s;
    end
  end

  // Registered read port with write-first bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= '0;
    end else if (bypass_s) begin
      read_data <= new_word_s;
    end else if (rd_in_range_s) begin
      read_data <= mem_r[read_addr];
    end else begin
      read_data <= '0;
    end
  end

endmodule

// File: tb/tb_cache_block_ram.sv
// Bench for cache_block_ram: three configurations driven from one vector table,
// expected read_data queued at drive time and compared after the edge.
module tb_cache_block_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // plain mode: 20-bit words, 128 entries
  logic        p_rst = 1'b0, p_wr_en = 1'b0;
  logic [6:0]  p_raddr = '0, p_waddr = '0;
  logic [19:0] p_wdata = '0, p_rdata;
  logic [3:0]  p_bs = '0;
  // byte mode: 32-bit words, 1024 entries
  logic        b_rst = 1'b0, b_wr_en = 1'b0;
  logic [9:0]  b_raddr = '0, b_waddr = '0;
  logic [31:0] b_wdata = '0, b_rdata;
  logic [3:0]  b_bs = '0;
  // single-bit words, 100 entries
  logic        s_rst = 1'b0, s_wr_en = 1'b0;
  logic [6:0]  s_raddr = '0, s_waddr = '0;
  logic [0:0]  s_wdata = '0, s_rdata;
  logic [3:0]  s_bs = '0;

  cache_block_ram #(.data_bits(20), .nr_entries(128), .use_bytesel(0)) u_plain (
    .clk(clk), .rst(p_rst), .read_addr(p_raddr), .read_data(p_rdata),
    .wr_en(p_wr_en), .write_addr(p_waddr), .write_data(p_wdata), .bytesel(p_bs));

  cache_block_ram #(.data_bits(32), .nr_entries(1024), .use_bytesel(1)) u_byte (
    .clk(clk), .rst(b_rst), .read_addr(b_raddr), .read_data(b_rdata),
    .wr_en(b_wr_en), .write_addr(b_waddr), .write_data(b_wdata), .bytesel(b_bs));

  cache_block_ram #(.data_bits(1), .nr_entries(100), .use_bytesel(0)) u_bit (
    .clk(clk), .rst(s_rst), .read_addr(s_raddr), .read_data(s_rdata),
    .wr_en(s_wr_en), .write_addr(s_waddr), .write_data(s_wdata), .bytesel(s_bs));

  typedef struct {
    int          sel;
    logic        rst;
    logic        wr_en;
    logic [9:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  bs;
    logic [9:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          sel;
    int          idx;
    logic [31:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic add(input int sel, input logic rst, input logic wr_en, input logic [9:0] waddr,
                     input logic [31:0] wdata, input logic [3:0] bs, input logic [9:0] raddr,
                     input logic [31:0] exp);
    vec_t v;
    v.sel = sel; v.rst = rst; v.wr_en = wr_en; v.waddr = waddr;
    v.wdata = wdata; v.bs = bs; v.raddr = raddr; v.exp = exp;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] dut_out(input int sel);
    if (sel == 0) return {12'h000, p_rdata};
    else if (sel == 1) return b_rdata;
    else return {31'h0, s_rdata};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    p_rst = 1'b0; p_wr_en = 1'b0;
    b_rst = 1'b0; b_wr_en = 1'b0;
    s_rst = 1'b0; s_wr_en = 1'b0;
    case (v.sel)
      0: begin
        p_rst = v.rst; p_wr_en = v.wr_en; p_waddr = v.waddr[6:0];
        p_wdata = v.wdata[19:0]; p_bs = v.bs; p_raddr = v.raddr[6:0];
      end
      1: begin
        b_rst = v.rst; b_wr_en = v.wr_en; b_waddr = v.waddr;
        b_wdata = v.wdata; b_bs = v.bs; b_raddr = v.raddr;
      end
      default: begin
        s_rst = v.rst; s_wr_en = v.wr_en; s_waddr = v.waddr[6:0];
        s_wdata = v.wdata[0]; s_bs = v.bs; s_raddr = v.raddr[6:0];
      end
    endcase
  endtask

  initial begin
    sb_t e;
    string nm;

    // plain mode
    add(0, 1, 0,   0, 32'h0,       4'b0000,   0, 32'h0);
    add(0, 0, 1,   5, 32'hABCDE,   4'b0000,   6, 32'h0);
    add(0, 0, 0,   0, 32'h0,       4'b0000,   5, 32'hABCDE);
    add(0, 0, 0,   0, 32'h0,       4'b0000,   6, 32'h0);
    add(0, 0, 1,   7, 32'h12345,   4'b0000,   7, 32'h12345);
    add(0, 0, 1, 127, 32'hFFFFF,   4'b0000,   5, 32'hABCDE);
    add(0, 0, 0,   0, 32'h0,       4'b0000, 127, 32'hFFFFF);
    // byte mode
    add(1, 1, 0,   0, 32'h0,         4'b0000,   0, 32'h0);
    add(1, 0, 1,   3, 32'h11223344,  4'b1111,   7, 32'h0);
    add(1, 0, 1,   3, 32'hAABBCCDD,  4'b0101,   3, 32'h11BB33DD);
    add(1, 0, 0,   0, 32'h0,         4'b0000,   3, 32'h11BB33DD);
    add(1, 0, 1,   0, 32'hFFFFFFFF,  4'b1111,   3, 32'h11BB33DD);
    add(1, 0, 1,   0, 32'h00000000,  4'b1000,   0, 32'h00FFFFFF);
    add(1, 0, 1,   0, 32'h12345678,  4'b0000,   0, 32'h00FFFFFF);
    add(1, 0, 0,   0, 32'h0,         4'b0000,   0, 32'h00FFFFFF);
    add(1, 0, 1,   9, 32'h7,         4'b1111,   9, 32'h7);
    add(1, 0, 1,  10, 32'h1,         4'b1111,   9, 32'h7);
    add(1, 0, 0,   0, 32'h0,         4'b0000,  10, 32'h1);
    add(1, 0, 1,   4, 32'hDEADBEEF,  4'b1111,   4, 32'hDEADBEEF);
    add(1, 1, 1,   2, 32'hCAFEF00D,  4'b1111,   4, 32'h0);
    add(1, 0, 0,   0, 32'h0,         4'b0000,   2, 32'hCAFEF00D);
    add(1, 0, 0,   0, 32'h0,         4'b0000,   3, 32'h11BB33DD);
    add(1, 0, 0,   0, 32'h0,         4'b0000,   4, 32'hDEADBEEF);
    add(1, 0, 1,   5, 32'h01010101,  4'b1111,   5, 32'h01010101);
    add(1, 0, 1,   5, 32'h02020202,  4'b0011,   5, 32'h01010202);
    add(1, 0, 0,   0, 32'h0,         4'b0000,   5, 32'h01010202);
    add(1, 0, 1, 1023, 32'hA5A5A5A5, 4'b1111, 1022, 32'h0);
    add(1, 0, 0,   0, 32'h0,         4'b0000, 1023, 32'hA5A5A5A5);
    // 1-bit words, 100 entries
    add(2, 1, 0,   0, 32'h0, 4'b0000,   0, 32'h0);
    add(2, 0, 1,  99, 32'h1, 4'b0000,  99, 32'h1);
    add(2, 0, 0,   0, 32'h0, 4'b0000,  99, 32'h1);
    add(2, 0, 1, 120, 32'h1, 4'b0000, 120, 32'h0);
    add(2, 0, 0,   0, 32'h0, 4'b0000, 120, 32'h0);
    add(2, 0, 0,   0, 32'h0, 4'b0000,  98, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      e.sel = vecs[i].sel; e.idx = i; e.exp = vecs[i].exp;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      nm = $sformatf("vec%0d", e.idx);
      check(nm, dut_out(e.sel), e.exp);
    end

    // read_data holds between edges and has no path from the inputs
    @(negedge clk);
    drive(vecs[0]);
    b_rst = 1'b0; b_wr_en = 1'b0; b_raddr = 10'd3;
    @(posedge clk);
    #1;
    check("hold_a", b_rdata, 32'h11BB33DD);
    b_raddr = 10'd4; b_wr_en = 1'b1; b_waddr = 10'd4; b_wdata = 32'h0; b_bs = 4'b1111;
    #2;
    check("no_comb_path", b_rdata, 32'h11BB33DD);
    @(negedge clk);
    check("hold_negedge", b_rdata, 32'h11BB33DD);
    @(posedge clk);
    #1;
    check("bypass_clear", b_rdata, 32'h0);
    b_wr_en = 1'b0;
    @(posedge clk);
    #1;
    check("after_clear", b_rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
